chip_interface: RTL and testbench

CHIP_INTERFACE -- requirements
Module: chip_interface

---
 rtl/chip_interface_pkg.sv | 43 ++++
 rtl/chip_interface_uart_tx.sv | 58 +++++
 rtl/chip_interface.sv | 175 +++++++++++++++++
 tb/tb_chip_interface.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/chip_interface_pkg.sv
// Shared constants, packet FSM state type and seven-segment decoder for the
// paddle controller.
package chip_interface_pkg;

  localparam logic [7:0] HEADER_BYTE      = 8'hFF;
  localparam int         DEF_CLKS_PER_BIT = 434;
  localparam int         DEF_MOVE_PERIOD  = 833_334;
  localparam int         DEF_PADDLE_MAX   = 200;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HDR,
    SEND_POS,
    SEND_FLAGS
  } pkt_state_t;

  // Active-low segments, bit6 = g ... bit0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/chip_interface_uart_tx.sv
// 8N1 UART transmitter. A send accepted on the final stop-bit cycle chains the
// next byte with no idle gap.
module uart_tx
  import chip_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_srst,
  input  logic [7:0] i_data,
  input  logic       i_send,
  output logic       o_txd,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);

  logic [CW-1:0] r_clk_cnt;
  logic [3:0]    r_bit_idx;
  logic [9:0]    r_frame;
  logic          r_busy;
  logic          w_bit_end;
  logic          w_done;
  logic          w_load;

  assign w_bit_end = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_done    = r_busy && w_bit_end && (r_bit_idx == 4'd9);
  assign w_load    = i_send && (!r_busy || w_done);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_busy    <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_frame   <= '1;
    end else if (w_load) begin
      r_busy    <= 1'b1;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_frame   <= {1'b1, i_data, 1'b0};
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        r_frame   <= {1'b1, r_frame[9:1]};
        if (r_bit_idx == 4'd9) r_busy <= 1'b0;
        else                   r_bit_idx <= r_bit_idx + 4'd1;
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
    end
  end

  assign o_txd  = r_busy ? r_frame[0] : 1'b1;
  assign o_busy = r_busy;
  assign o_done = w_done;

endmodule

// File: rtl/chip_interface.sv
// Paddle controller: joystick moves a saturating paddle position, which is
// streamed continuously over UART as {0xFF, position, flags} packets.
module chip_interface
  import chip_interface_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MOVE_PERIOD  = DEF_MOVE_PERIOD,
  parameter int PADDLE_MAX   = DEF_PADDLE_MAX
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  input  logic        JOY_UP,
  input  logic        JOY_DOWN,
  input  logic        ARCADE_BUTTON,
  input  logic        UART_RXD,
  input  logic        UART_RTS,
  input  logic        NEO_IN,
  output logic        UART_TXD,
  output logic        UART_CTS,
  output logic        NEO_OUT,
  output logic        ARCADE_LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic [17:0] LEDR,
  output logic [7:0]  LEDG,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_BLANK_N,
  output logic        VGA_CLK,
  output logic        VGA_SYNC_N,
  output logic        VGA_VS,
  output logic        VGA_HS
);

  localparam int         MCW     = $clog2(MOVE_PERIOD + 1);
  localparam logic [7:0] POS_MAX = 8'(PADDLE_MAX);

  logic            w_srst;
  logic            w_unused;
  logic            r_up_s1, r_up_s2, r_dn_s1, r_dn_s2, r_btn_s1, r_btn_s2;
  logic [MCW-1:0]  r_move_cnt;
  logic            w_tick;
  logic [7:0]      r_pos;
  logic [7:0]      r_pkt_pos;
  logic [7:0]      r_pkt_flags;
  pkt_state_t      r_state, w_state_next;
  logic            w_send, w_capture;
  logic [7:0]      w_tx_data;
  logic            w_tx_busy, w_tx_done, w_txd;

  assign w_srst   = ~KEY[0];
  assign w_unused = ^{SW, KEY[3:1], UART_RXD, UART_RTS, NEO_IN};

  always_ff @(posedge CLOCK_50) begin
    if (w_srst) begin
      {r_up_s1, r_up_s2, r_dn_s1, r_dn_s2, r_btn_s1, r_btn_s2} <= '0;
    end else begin
      r_up_s1  <= JOY_UP;
      r_up_s2  <= r_up_s1;
      r_dn_s1  <= JOY_DOWN;
      r_dn_s2  <= r_dn_s1;
      r_btn_s1 <= ARCADE_BUTTON;
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_tick = (r_move_cnt == MCW'(MOVE_PERIOD - 1));

  always_ff @(posedge CLOCK_50) begin
    if (w_srst) begin
      r_move_cnt <= '0;
      r_pos      <= '0;
    end else begin
      r_move_cnt <= w_tick ? '0 : r_move_cnt + MCW'(1);
      if (w_tick) begin
        if (r_up_s2 && !r_dn_s2 && (r_pos < POS_MAX))
          r_pos <= r_pos + 8'd1;
        else if (r_dn_s2 && !r_up_s2 && (r_pos != 8'd0))
          r_pos <= r_pos - 8'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (w_srst) begin
      r_state     <= IDLE;
      r_pkt_pos   <= '0;
      r_pkt_flags <= '0;
    end else begin
      r_state <= w_state_next;
      // Snapshot the payload as the header goes out so the packet is coherent.
      if (w_capture) begin
        r_pkt_pos   <= r_pos;
        r_pkt_flags <= {7'b0, r_btn_s2};
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_send       = 1'b0;
    w_capture    = 1'b0;
    w_tx_data    = HEADER_BYTE;
    case (r_state)
      IDLE: begin
        if (!w_tx_busy) begin
          w_send       = 1'b1;
          w_capture    = 1'b1;
          w_tx_data    = HEADER_BYTE;
          w_state_next = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (w_tx_done) begin
          w_send       = 1'b1;
          w_tx_data    = r_pkt_pos;
          w_state_next = SEND_POS;
        end
      end
      SEND_POS: begin
        if (w_tx_done) begin
          w_send       = 1'b1;
          w_tx_data    = r_pkt_flags;
          w_state_next = SEND_FLAGS;
        end
      end
      SEND_FLAGS: begin
        if (w_tx_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
    .i_clk  (CLOCK_50),
    .i_srst (w_srst),
    .i_data (w_tx_data),
    .i_send (w_send),
    .o_txd  (w_txd),
    .o_busy (w_tx_busy),
    .o_done (w_tx_done)
  );

  assign UART_TXD    = w_txd;
  assign UART_CTS    = 1'b0;
  assign NEO_OUT     = 1'b0;
  assign ARCADE_LED  = r_btn_s2;
  assign HEX0        = seg7(r_pos[3:0]);
  assign HEX1        = seg7(r_pos[7:4]);
  assign HEX2        = 7'h7F;
  assign HEX3        = 7'h7F;
  assign HEX4        = 7'h7F;
  assign HEX5        = 7'h7F;
  assign HEX6        = 7'h7F;
  assign HEX7        = 7'h7F;
  assign LEDR        = {10'b0, r_pos};
  assign LEDG        = {5'b0, r_dn_s2, r_up_s2, w_tx_busy};
  assign VGA_R       = 8'h00;
  assign VGA_G       = 8'h00;
  assign VGA_B       = 8'h00;
  assign VGA_BLANK_N = 1'b0;
  assign VGA_CLK     = 1'b0;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_VS      = 1'b0;
  assign VGA_HS      = 1'b0;

endmodule

// File: tb/tb_chip_interface.sv
// Randomized bench for chip_interface: a reference model predicts packets into a
// queue and a UART monitor decodes TXD frames and compares them.
module tb_chip_interface;

  localparam int CPB  = 4;
  localparam int MP   = 10;
  localparam int PMAX = 200;
  localparam int PKT  = 30 * CPB + 1;
  localparam int FLEN = 10 * CPB;

  logic        clk = 1'b0;
  logic [3:0]  key = 4'hE;
  logic [17:0] sw = '0;
  logic        joy_up = 1'b0, joy_dn = 1'b0, btn = 1'b0;
  logic        uart_txd, uart_cts, neo_out, arcade_led;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [17:0] ledr;
  logic [7:0]  ledg, vga_r, vga_g, vga_b;
  logic        vga_blank_n, vga_clk, vga_sync_n, vga_vs, vga_hs;

  always #5 clk = ~clk;

  chip_interface #(.CLKS_PER_BIT(CPB), .MOVE_PERIOD(MP), .PADDLE_MAX(PMAX)) dut (
    .CLOCK_50(clk), .KEY(key), .SW(sw), .JOY_UP(joy_up), .JOY_DOWN(joy_dn),
    .ARCADE_BUTTON(btn), .UART_RXD(1'b1), .UART_RTS(1'b0), .NEO_IN(1'b0),
    .UART_TXD(uart_txd), .UART_CTS(uart_cts), .NEO_OUT(neo_out), .ARCADE_LED(arcade_led),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .HEX6(hex6), .HEX7(hex7), .LEDR(ledr), .LEDG(ledg),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_BLANK_N(vga_blank_n),
    .VGA_CLK(vga_clk), .VGA_SYNC_N(vga_sync_n), .VGA_VS(vga_vs), .VGA_HS(vga_hs)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_seg(input int v);
    case (v)
      0: return 'h40;  1: return 'h79;  2: return 'h24;  3: return 'h30;
      4: return 'h19;  5: return 'h12;  6: return 'h02;  7: return 'h78;
      8: return 'h00;  9: return 'h10; 10: return 'h08; 11: return 'h03;
      12: return 'h46; 13: return 'h21; 14: return 'h06; default: return 'h0E;
    endcase
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
  endfunction

  // Reference model: edges since reset release decide move ticks and packet
  // starts; inputs take effect two edges after they are applied.
  int         m_e = 0;
  int         m_pos = 0;
  logic [1:0] h_up = '0, h_dn = '0, h_bt = '0;
  logic       m_in_rst = 1'b0;
  logic [7:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk);
      m_in_rst = ~key[0];
      if (!key[0]) begin
        m_e = 0; m_pos = 0; h_up = '0; h_dn = '0; h_bt = '0;
        exp_q.delete();
      end else begin
        if (m_e % PKT == 0) begin
          exp_q.push_back(8'hFF);
          exp_q.push_back(8'(m_pos));
          exp_q.push_back({7'b0, h_bt[1]});
        end
        if ((m_e + 1) % MP == 0)
          m_pos = clamp(m_pos + int'(h_up[1]) - int'(h_dn[1]));
        h_up = {h_up[0], joy_up};
        h_dn = {h_dn[0], joy_dn};
        h_bt = {h_bt[0], btn};
        m_e  = m_e + 1;
      end
    end
  end

  // UART monitor: decodes each frame over its full 10-bit window.
  int         frames = 0;
  logic       in_frame = 1'b0;
  int         fcnt = 0;
  logic       busy_ok = 1'b1;
  logic [7:0] cur_exp = '0;
  logic       samp [FLEN];

  initial begin
    forever begin
      @(negedge clk);
      if (m_in_rst) begin
        check("reset_txd", int'(uart_txd), 1);
        check("reset_busy", int'(ledg[0]), 0);
        in_frame = 1'b0;
        fcnt = 0;
      end else begin
        if (!in_frame && uart_txd == 1'b0) begin
          in_frame = 1'b1;
          fcnt = 0;
          busy_ok = 1'b1;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 0, 1);
            cur_exp = 8'h00;
          end else begin
            cur_exp = exp_q.pop_front();
          end
        end
        if (in_frame) begin
          samp[fcnt] = uart_txd;
          if (!ledg[0]) busy_ok = 1'b0;
          fcnt++;
          if (fcnt == FLEN) begin
            logic [7:0] got;
            logic       framing;
            got = '0;
            framing = busy_ok && (samp[0] == 1'b0) && (samp[9*CPB] == 1'b1);
            for (int b = 0; b < 10; b++) begin
              for (int j = 1; j < CPB; j++)
                if (samp[b*CPB+j] != samp[b*CPB]) framing = 1'b0;
              if (b >= 1 && b <= 8) got[b-1] = samp[b*CPB];
            end
            check($sformatf("frame%0d_byte", frames), int'(got), int'(cur_exp));
            check($sformatf("frame%0d_framing", frames), int'(framing), 1);
            frames++;
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic check_state(input string tag);
    check({tag, "_pos"}, int'(ledr[7:0]), m_pos);
    check({tag, "_ledr_hi"}, int'(ledr[17:8]), 0);
    check({tag, "_hex0"}, int'(hex0), exp_seg(m_pos % 16));
    check({tag, "_hex1"}, int'(hex1), exp_seg(m_pos / 16));
    check({tag, "_led"}, int'(arcade_led), int'(h_bt[1]));
    check({tag, "_ledg_joy"}, int'(ledg[2:1]), int'({h_dn[1], h_up[1]}));
  endtask

  initial begin
    repeat (10) @(negedge clk);
    check("reset_hex0", int'(hex0), exp_seg(0));
    check("reset_hex1", int'(hex1), exp_seg(0));
    check("reset_pos", int'(ledr), 0);
    check("hex_blank", int'(hex7), 'h7F);
    key[0] = 1'b1;
    @(negedge clk);
    check("first_start_bit", int'(uart_txd), 0);

    repeat (2 * PKT + 10) @(negedge clk);
    check_state("idle");

    joy_up = 1'b1;
    repeat (2500 * MP) @(negedge clk);
    check("pos_sat_max", int'(ledr[7:0]), 200);
    check("hex_c8_lo", int'(hex0), exp_seg(8));
    check("hex_c8_hi", int'(hex1), exp_seg(12));
    check_state("up");

    joy_dn = 1'b1;
    repeat (50 * MP) @(negedge clk);
    check("pos_both_hold", int'(ledr[7:0]), 200);
    check_state("both");

    joy_up = 1'b0;
    repeat (250 * MP) @(negedge clk);
    check("pos_sat_min", int'(ledr[7:0]), 0);
    repeat (30 * MP) @(negedge clk);
    check("pos_min_hold", int'(ledr[7:0]), 0);
    check_state("down");
    joy_dn = 1'b0;

    btn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("button_led", int'(arcade_led), 1);
    repeat (2 * PKT) @(negedge clk);
    btn = 1'b0;

    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if ($urandom_range(19) == 0) begin
        joy_up = 1'($urandom_range(1));
        joy_dn = 1'($urandom_range(1));
        btn    = 1'($urandom_range(1));
      end
      if (i % 500 == 499) check_state("rand");
    end

    // Land reset in the middle of the position byte.
    for (int i = 0; i < PKT + 5; i++) begin
      if (m_e % PKT == 55) break;
      @(negedge clk);
    end
    check("reset_phase", m_e % PKT, 55);
    key[0] = 1'b0;
    repeat (5) @(negedge clk);
    key[0] = 1'b1;
    @(negedge clk);
    check("restart_start_bit", int'(uart_txd), 0);
    repeat (2 * PKT) @(negedge clk);
    check_state("final");

    check("frame_count_ok", int'(frames > 900), 1);
    check("queue_drained", int'(exp_q.size() <= 3), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
